// File: rtl/freq_sel_pkg.sv
// rtl/freq_sel_pkg.sv - shared sizes and FSM state codes for the corner-turn buffer
// Default geometry: N_FREQ channels per frame, NPT = DEPTH/ASSERT samples per series.
// Writer states: HUNT (wait for index 0), FILL (writing a bank), BLOCKED (both banks full).
// Reader states: IDLE (wait for a full bank), RUN (replaying a bank).
package freq_sel_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_N_FREQ     = 128;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_ASSERT     = 2;

  localparam int NPT = DEF_DEPTH / DEF_ASSERT;
  localparam int CW  = $clog2(DEF_DEPTH) - $clog2(DEF_ASSERT);
  localparam int IW  = $clog2(DEF_N_FREQ);
  localparam int AW  = 1 + IW + CW;

  localparam logic [1:0] WR_HUNT    = 2'd0;
  localparam logic [1:0] WR_FILL    = 2'd1;
  localparam logic [1:0] WR_BLOCKED = 2'd2;

  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RUN  = 1'b1;

endpackage

// File: rtl/corner_turn_ram.sv
// rtl/corner_turn_ram.sv - simple dual-port sample store with registered read
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
// rd_data valid the cycle after rd_en. The array itself carries no reset.
module corner_turn_ram
  import freq_sel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = AW
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/corner_turn_buffer.sv
// rtl/corner_turn_buffer.sv - double-buffered corner turn feeding second_fft
// Input side:  s_data/s_index/s_valid, s_ready (low only in reset; overflow drops).
// Output side: m_data/m_count(t)/m_index(f)/m_valid with m_ready backpressure.
// Status:      banks_full per bank, ovf_frames and sync_err saturating counters.
// Frames are written as RAM[{bank,f,t}]; each full bank is replayed f-major, t-minor.
module corner_turn_buffer
  import freq_sel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_FREQ     = DEF_N_FREQ,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ASSERT     = DEF_ASSERT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   s_data,
  input  logic [$clog2(N_FREQ)-1:0]               s_index,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [DATA_WIDTH-1:0]                   m_data,
  output logic [$clog2(DEPTH)-$clog2(ASSERT)-1:0] m_count,
  output logic [$clog2(N_FREQ)-1:0]               m_index,
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic [1:0]                              banks_full,
  output logic [15:0]                             ovf_frames,
  output logic [15:0]                             sync_err
);

  localparam int NPT_L = DEPTH / ASSERT;
  localparam int IW_L  = $clog2(N_FREQ);
  localparam int CW_L  = $clog2(DEPTH) - $clog2(ASSERT);
  localparam int AW_L  = 1 + IW_L + CW_L;
  localparam int BW    = IW_L + CW_L + DATA_WIDTH;
  localparam logic [IW_L-1:0] LAST_F = IW_L'(N_FREQ - 1);
  localparam logic [CW_L-1:0] LAST_T = CW_L'(NPT_L - 1);

  logic [1:0]      wr_state;
  logic            wr_bank;
  logic [CW_L-1:0] wr_t;
  logic [IW_L-1:0] exp_idx;
  logic            accept, wr_en, err_hit, lose_sync, frame_done, bank_done, other_free;
  logic [1:0]      banks_full_next;

  logic            rd_state, rd_bank, rd_issue, rd_done, rd_all, pop, fly;
  logic [IW_L-1:0] rd_f, iss_f, fly_f;
  logic [CW_L-1:0] rd_t, iss_t, fly_t;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [1:0]      sk_cnt;
  logic [BW-1:0]   sk0, sk1, new_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s_ready <= 1'b0;
    else     s_ready <= 1'b1;
  end

  assign accept = s_valid && s_ready;

  // In HUNT exp_idx is always 0, so an index-0 sample matches and starts a frame.
  always_comb begin
    wr_en     = 1'b0;
    err_hit   = 1'b0;
    lose_sync = 1'b0;
    if (accept && wr_state != WR_BLOCKED) begin
      if (s_index == exp_idx) begin
        wr_en = 1'b1;
      end else if (wr_state == WR_FILL) begin
        err_hit = 1'b1;
        if (s_index == '0) wr_en = 1'b1;  // restart frame at the same wr_t
        else               lose_sync = 1'b1;
      end
    end
  end

  assign frame_done = wr_en && (s_index == LAST_F);
  assign bank_done  = frame_done && (wr_t == LAST_T);
  // A bank the reader releases this very cycle already counts as free.
  assign other_free = !banks_full[~wr_bank] || (rd_done && (rd_bank == ~wr_bank));

  always_comb begin
    banks_full_next = banks_full;
    if (bank_done) banks_full_next[wr_bank] = 1'b1;
    if (rd_done)   banks_full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state   <= WR_HUNT;
      wr_bank    <= 1'b0;
      wr_t       <= '0;
      exp_idx    <= '0;
      banks_full <= 2'b00;
      sync_err   <= '0;
      ovf_frames <= '0;
    end else begin
      banks_full <= banks_full_next;
      if (err_hit && sync_err != 16'hFFFF) sync_err <= sync_err + 16'd1;
      if (wr_state == WR_BLOCKED && accept && s_index == LAST_F && ovf_frames != 16'hFFFF)
        ovf_frames <= ovf_frames + 16'd1;
      case (wr_state)
        WR_BLOCKED: begin
          if (!banks_full[~wr_bank]) begin
            wr_bank  <= ~wr_bank;
            wr_t     <= '0;
            exp_idx  <= '0;
            wr_state <= WR_HUNT;
          end
        end
        default: begin
          if (wr_en) begin
            if (frame_done) begin
              exp_idx <= '0;
              if (!bank_done) begin
                wr_t     <= wr_t + 1'b1;
                wr_state <= WR_FILL;
              end else if (other_free) begin
                wr_bank  <= ~wr_bank;
                wr_t     <= '0;
                wr_state <= WR_FILL;
              end else begin
                wr_state <= WR_BLOCKED;
              end
            end else begin
              exp_idx  <= s_index + 1'b1;
              wr_state <= WR_FILL;
            end
          end else if (lose_sync) begin
            exp_idx  <= '0;
            wr_state <= WR_HUNT;
          end
        end
      endcase
    end
  end

  // Reader: head of the 2-entry skid register drives the output port.
  assign {m_index, m_count, m_data} = sk0;
  assign m_valid  = (sk_cnt != 2'd0);
  assign pop      = m_valid && m_ready;
  assign rd_done  = (rd_state == RD_RUN) && pop && (sk0[BW-1 -: IW_L+CW_L] == {LAST_F, LAST_T});
  assign new_beat = {fly_f, fly_t, ram_q};

  // Issue a read only if the skid can absorb it counting the read already in flight.
  always_comb begin
    iss_f    = rd_f;
    iss_t    = rd_t;
    rd_issue = 1'b0;
    if (rd_state == RD_IDLE) begin
      iss_f    = '0;
      iss_t    = '0;
      rd_issue = banks_full[rd_bank];
    end else begin
      rd_issue = !rd_all && (({1'b0, sk_cnt} + {2'b00, fly}) < (3'd2 + {2'b00, pop}));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_bank  <= 1'b0;
      rd_f     <= '0;
      rd_t     <= '0;
      rd_all   <= 1'b0;
      fly      <= 1'b0;
      fly_f    <= '0;
      fly_t    <= '0;
    end else begin
      fly <= rd_issue;
      if (rd_issue) begin
        fly_f    <= iss_f;
        fly_t    <= iss_t;
        rd_state <= RD_RUN;
        rd_all   <= (iss_f == LAST_F) && (iss_t == LAST_T);
        if (iss_t == LAST_T) begin
          rd_t <= '0;
          rd_f <= iss_f + 1'b1;
        end else begin
          rd_t <= iss_t + 1'b1;
          rd_f <= iss_f;
        end
      end
      if (rd_done) begin
        rd_state <= RD_IDLE;
        rd_bank  <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sk_cnt <= 2'd0;
      sk0    <= '0;
      sk1    <= '0;
    end else begin
      case ({fly, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) sk0 <= new_beat;
          else                sk1 <= new_beat;
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          sk0    <= sk1;
          sk_cnt <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            sk0 <= new_beat;
          end else begin
            sk0 <= sk1;
            sk1 <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

  corner_turn_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW_L)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr({wr_bank, s_index, wr_t}),
    .wr_data(s_data),
    .rd_en  (rd_issue),
    .rd_addr({rd_bank, iss_f, iss_t}),
    .rd_data(ram_q)
  );

endmodule

// File: tb/tb_corner_turn_buffer.sv
// tb/tb_corner_turn_buffer.sv - directed/randomized bench for corner_turn_buffer
module tb_corner_turn_buffer;

  localparam int DW = 64;
  localparam int NF = 128;
  localparam int DEPTH = 32;
  localparam int ASSERT = 2;
  localparam int NPT = DEPTH / ASSERT;
  localparam int IW = $clog2(NF);
  localparam int CW = $clog2(NPT);
  localparam int BANK_BEATS = NF * NPT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic [IW-1:0] s_index = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_count;
  logic [IW-1:0] m_index;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [1:0]    banks_full;
  logic [15:0]   ovf_frames;
  logic [15:0]   sync_err;

  int n_tests = 0;
  int n_fail = 0;
  int ready_mode = 0;  // 0 always ready, 1 random, 2 never, 3 driven by main sequence
  bit gaps_on = 1'b0;

  logic [IW+CW+DW-1:0] got_q[$];
  logic [31:0]         exp_frames[$];  // tags of frames that must land in the RAM, in order

  always #5 clk = ~clk;

  corner_turn_buffer #(
    .DATA_WIDTH(DW), .N_FREQ(NF), .DEPTH(DEPTH), .ASSERT(ASSERT)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_index(s_index), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_count(m_count), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
    .banks_full(banks_full), .ovf_frames(ovf_frames), .sync_err(sync_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic                stall_q = 1'b0;
  logic [IW+CW+DW-1:0] held_q = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", m_valid, 1);
        check("hold_beat", {m_index, m_count, m_data}, held_q);
      end
      if (m_valid && m_ready) got_q.push_back({m_index, m_count, m_data});
      stall_q <= m_valid && !m_ready;
      held_q  <= {m_index, m_count, m_data};
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(0, 1));
      2: m_ready = 1'b0;
      default: ;
    endcase
  end

  task automatic send_sample(input logic [31:0] tag, input int idx);
    if (gaps_on && $urandom_range(0, 7) == 0) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_index = IW'(idx);
    s_data  = {tag, 32'(idx)};
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_range(input logic [31:0] tag, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_sample(tag, i);
  endtask

  task automatic send_frame(input logic [31:0] tag, input bit store);
    send_range(tag, 0, NF - 1);
    if (store) exp_frames.push_back(tag);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("beat_timeout", got_q.size() >= n, 1);
  endtask

  // Every 16 stored frames form one bank; a bank replays f-major, t-minor.
  task automatic check_beats(input string tag);
    int n;
    n = exp_frames.size() / NPT * BANK_BEATS;
    check({tag, "_count"}, got_q.size(), n);
    for (int k = 0; k < n; k++) begin
      int g, f, t;
      g = k / BANK_BEATS;
      f = (k % BANK_BEATS) / NPT;
      t = k % NPT;
      if (k < got_q.size())
        check($sformatf("%s_beat%0d", tag, k), got_q[k],
              {IW'(f), CW'(t), exp_frames[g*NPT+t], 32'(f)});
    end
    got_q.delete();
    exp_frames.delete();
  endtask

  initial begin
    logic [31:0] tg;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", {m_index, m_count, m_data}, 0);
    check("rst_banks_full", banks_full, 0);
    check("rst_ovf", ovf_frames, 0);
    check("rst_sync", sync_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_up", s_ready, 1);

    // clean fill, data = {t,f}
    ready_mode = 0;
    for (int t = 0; t < NPT; t++) send_frame(32'(t), 1'b1);
    check("clean_banks_full", banks_full, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    check("clean_latency", m_valid, 1);
    wait_beats(BANK_BEATS, 4000);
    if (got_q.size() > 5 * NPT + 3) check("beat_f5_t3", got_q[5*NPT+3][DW-1:0], {32'd3, 32'd5});
    repeat (4) @(posedge clk);
    #1;
    check("clean_drained", banks_full, 2'b00);
    check_beats("clean");
    check("clean_sync", sync_err, 0);
    check("clean_ovf", ovf_frames, 0);

    // backpressure with random data and input gaps
    ready_mode = 1;
    gaps_on = 1'b1;
    for (int t = 0; t < NPT; t++) send_frame($urandom, 1'b1);
    wait_beats(BANK_BEATS, 9000);
    check_beats("bp");
    check("bp_ovf", ovf_frames, 0);

    // final write of the second bank lands on the final accept of the first
    ready_mode = 3;
    m_ready = 1'b0;
    gaps_on = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 2 * NPT - 1; i++) send_frame($urandom, 1'b1);
    tg = $urandom;
    send_range(tg, 0, NF - 2);
    exp_frames.push_back(tg);
    k = 0;
    while (!(m_valid && m_index == IW'(NF - 1) && m_count == CW'(NPT - 1)) && k < 3000) begin
      m_ready = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    m_ready = 1'b0;
    check("simul_at_last", m_valid && m_index == IW'(NF - 1) && m_count == CW'(NPT - 1), 1);
    s_valid = 1'b1;
    s_index = IW'(NF - 1);
    s_data  = {tg, 32'(NF - 1)};
    m_ready = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("simul_banks_full", banks_full, 2'b10);
    for (int t = 0; t < NPT; t++) send_frame($urandom, 1'b1);
    wait_beats(3 * BANK_BEATS, 9000);
    check_beats("simul");
    check("simul_ovf", ovf_frames, 0);

    // index errors: 9->11 jump, then mid-frame restart
    gaps_on = 1'b1;
    send_frame($urandom, 1'b1);
    send_frame($urandom, 1'b1);
    tg = $urandom;
    send_range(tg, 0, 9);
    send_range(tg, 11, NF - 1);
    check("jump_sync", sync_err, 1);
    send_frame($urandom, 1'b1);
    send_range($urandom, 0, 49);
    send_frame($urandom, 1'b1);
    check("restart_sync", sync_err, 2);
    for (int i = 0; i < NPT - 4; i++) send_frame($urandom, 1'b1);
    wait_beats(BANK_BEATS, 4000);
    check_beats("idx");

    // overflow: 48 frames with the output stalled
    ready_mode = 2;
    for (int i = 0; i < 3 * NPT; i++) send_frame($urandom, i < 2 * NPT);
    check("ovf_banks_full", banks_full, 2'b11);
    check("ovf_count", ovf_frames, 16);
    ready_mode = 0;
    wait_beats(BANK_BEATS, 4000);
    repeat (5) @(posedge clk);
    #1;
    send_range($urandom, 60, NF - 1);
    for (int t = 0; t < NPT; t++) send_frame($urandom, 1'b1);
    wait_beats(3 * BANK_BEATS, 12000);
    check_beats("ovf");
    check("ovf_hold", ovf_frames, 16);
    check("ovf_sync", sync_err, 2);

    // asynchronous reset mid-burst
    gaps_on = 1'b0;
    for (int t = 0; t < NPT; t++) send_frame($urandom, 1'b1);
    wait_beats(700, 3000);
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_s_ready", s_ready, 0);
    check("arst_ovf", ovf_frames, 0);
    check("arst_sync", sync_err, 0);
    check("arst_banks_full", banks_full, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    exp_frames.delete();
    @(posedge clk); #1;
    for (int t = 0; t < NPT; t++) send_frame($urandom, 1'b1);
    wait_beats(BANK_BEATS, 4000);
    check_beats("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
